// File: rtl/pipeline_mem2wb_skid.sv
// -----------------------------------------------------------------------------
// pipeline_mem2wb_skid
//
// MEM-to-WB pipeline register with LANES parallel writeback lanes and a
// valid/ready handshake. A two-entry skid buffer (main register M driving the
// outputs, skid register S catching the bundle accepted while WB stalls)
// lets in_ready come straight from state, so MEM never sees a combinational
// path from WB back-pressure. All lanes are stored and moved as one bundle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    squash held and incoming bundles
//   in_valid / in_ready      MEM-side handshake (in_ready is registered)
//   wb_reg_in                per-lane write enable
//   wb_data_in               per-lane data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   virtual_write_addr_in    per-lane architectural destination
//   physical_write_addr_in   per-lane physical destination
//   active_list_index_in     per-lane active-list index
//   out_valid / out_ready    WB-side handshake
//   wb_reg_out               per-lane write enable, gated by out_valid
//   *_out payload            contents of M, valid or not
//   stall_cycles             saturating count of out_valid & !out_ready cycles
// -----------------------------------------------------------------------------
module pipeline_mem2wb_skid #(
    parameter int LANES           = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int VREG_WIDTH      = 5,
    parameter int PREG_WIDTH      = 6,
    parameter int FREE_LIST_WIDTH = 3,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES-1:0]                 wb_reg_in,
    input  logic [LANES*DATA_WIDTH-1:0]      wb_data_in,
    input  logic [LANES*VREG_WIDTH-1:0]      virtual_write_addr_in,
    input  logic [LANES*PREG_WIDTH-1:0]      physical_write_addr_in,
    input  logic [LANES*FREE_LIST_WIDTH-1:0] active_list_index_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES-1:0]                 wb_reg_out,
    output logic [LANES*DATA_WIDTH-1:0]      wb_data_out,
    output logic [LANES*VREG_WIDTH-1:0]      virtual_write_addr_out,
    output logic [LANES*PREG_WIDTH-1:0]      physical_write_addr_out,
    output logic [LANES*FREE_LIST_WIDTH-1:0] active_list_index_out,
    output logic [STALL_CNT_WIDTH-1:0]       stall_cycles
);

    // Packed bundle layout, LSB first: active-list index, physical addr,
    // virtual addr, data, write enables.
    localparam int ALI_W  = LANES*FREE_LIST_WIDTH;
    localparam int PREG_W = LANES*PREG_WIDTH;
    localparam int VREG_W = LANES*VREG_WIDTH;
    localparam int DAT_W  = LANES*DATA_WIDTH;
    localparam int WB_W   = LANES;
    localparam int ALI_LO  = 0;
    localparam int PREG_LO = ALI_LO + ALI_W;
    localparam int VREG_LO = PREG_LO + PREG_W;
    localparam int DAT_LO  = VREG_LO + VREG_W;
    localparam int WB_LO   = DAT_LO + DAT_W;
    localparam int PW      = WB_LO + WB_W;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_e;

    state_e                     state_q, state_d;
    logic [PW-1:0]              m_q, m_d;
    logic [PW-1:0]              s_q, s_d;
    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
    logic [PW-1:0]              in_bundle;
    logic                       acc;
    logic                       pop;

    assign in_bundle = {wb_reg_in, wb_data_in, virtual_write_addr_in,
                        physical_write_addr_in, active_list_index_in};

    // M is valid in ONE and FULL; S is valid only in FULL.
    assign out_valid = (state_q == ONE) || (state_q == FULL);
    assign in_ready  = (state_q != FULL);
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    m_d     = in_bundle;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    m_d = in_bundle;
                end else if (acc) begin
                    s_d     = in_bundle;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    m_d     = s_q;
                    s_d     = '0;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
                m_d     = '0;
                s_d     = '0;
            end
        endcase
        // Flush overrides any transition, including a bundle accepted now.
        if (flush) begin
            state_d = EMPTY;
            m_d     = '0;
            s_d     = '0;
        end
    end

    // Saturating back-pressure counter; flush deliberately leaves it alone.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {STALL_CNT_WIDTH{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            stall_q <= stall_d;
        end
    end

    assign wb_reg_out              = m_q[WB_LO +: WB_W] & {LANES{out_valid}};
    assign wb_data_out             = m_q[DAT_LO +: DAT_W];
    assign virtual_write_addr_out  = m_q[VREG_LO +: VREG_W];
    assign physical_write_addr_out = m_q[PREG_LO +: PREG_W];
    assign active_list_index_out   = m_q[ALI_LO +: ALI_W];
    assign stall_cycles            = stall_q;

endmodule

// File: tb/tb_pipeline_mem2wb_skid.sv
// -----------------------------------------------------------------------------
// Testbench for pipeline_mem2wb_skid: a default-parameter instance for the
// functional scenarios and a single-lane instance with a 4-bit stall counter
// for saturation.
// -----------------------------------------------------------------------------
module tb_pipeline_mem2wb_skid;

    localparam int LANES = 2;
    localparam int DW    = 32;
    localparam int VW    = 5;
    localparam int PWD   = 6;
    localparam int FW    = 3;
    localparam int SW    = 16;

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES-1:0]      wb_reg_in;
    logic [LANES*DW-1:0]   wb_data_in;
    logic [LANES*VW-1:0]   vaddr_in;
    logic [LANES*PWD-1:0]  paddr_in;
    logic [LANES*FW-1:0]   ali_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES-1:0]      wb_reg_out;
    logic [LANES*DW-1:0]   wb_data_out;
    logic [LANES*VW-1:0]   vaddr_out;
    logic [LANES*PWD-1:0]  paddr_out;
    logic [LANES*FW-1:0]   ali_out;
    logic [SW-1:0]         stall_cycles;

    // Saturation instance (LANES=1, STALL_CNT_WIDTH=4)
    logic          s_rst;
    logic          s_in_valid;
    logic          s_in_ready;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [0:0]    s_wb_reg_out;
    logic [DW-1:0] s_data_out;
    logic [VW-1:0] s_vaddr_out;
    logic [PWD-1:0] s_paddr_out;
    logic [FW-1:0] s_ali_out;
    logic [3:0]    s_stall;

    int checks;
    int failures;

    pipeline_mem2wb_skid #(
        .LANES(LANES), .DATA_WIDTH(DW), .VREG_WIDTH(VW),
        .PREG_WIDTH(PWD), .FREE_LIST_WIDTH(FW), .STALL_CNT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .wb_reg_in(wb_reg_in), .wb_data_in(wb_data_in),
        .virtual_write_addr_in(vaddr_in), .physical_write_addr_in(paddr_in),
        .active_list_index_in(ali_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_reg_out(wb_reg_out), .wb_data_out(wb_data_out),
        .virtual_write_addr_out(vaddr_out), .physical_write_addr_out(paddr_out),
        .active_list_index_out(ali_out), .stall_cycles(stall_cycles)
    );

    pipeline_mem2wb_skid #(
        .LANES(1), .DATA_WIDTH(DW), .VREG_WIDTH(VW),
        .PREG_WIDTH(PWD), .FREE_LIST_WIDTH(FW), .STALL_CNT_WIDTH(4)
    ) dut_sat (
        .clk(clk), .rst(s_rst), .flush(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .wb_reg_in(1'b1), .wb_data_in(32'h0000_00A5),
        .virtual_write_addr_in(5'd1), .physical_write_addr_in(6'd2),
        .active_list_index_in(3'd3),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .wb_reg_out(s_wb_reg_out), .wb_data_out(s_data_out),
        .virtual_write_addr_out(s_vaddr_out), .physical_write_addr_out(s_paddr_out),
        .active_list_index_out(s_ali_out), .stall_cycles(s_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] we, input logic [31:0] d0);
        in_valid   = v;
        wb_reg_in  = we;
        wb_data_in = {32'h0, d0};
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'b00, 32'h0);
        vaddr_in = '0; paddr_in = '0; ali_in = '0;
        step(); step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        checks++;
        if (wb_reg_out !== 2'b00 || stall_cycles !== 16'd0 || wb_data_out !== 64'd0) begin
            failures++;
            $display("FAIL reset_payload: wb_reg=%b stall=%0d data=%h want 00/0/0",
                     wb_reg_out, stall_cycles, wb_data_out);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL reset_idle: out_valid=%b in_ready=%b stall=%0d want 0/1/0",
                     out_valid, in_ready, stall_cycles);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] seq [3];
        seq[0] = 32'h1111_1111; seq[1] = 32'h2222_2222; seq[2] = 32'h3333_3333;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, seq[i]);
            step();
            checks++;
            if (out_valid !== 1'b1 || wb_data_out[31:0] !== seq[i] || in_ready !== 1'b1
                || stall_cycles !== 16'd0 || wb_reg_out !== 2'b01) begin
                failures++;
                $display("FAIL stream_%0d: valid=%b data=%h rdy=%b stall=%0d we=%b want 1/%h/1/0/01",
                         i, out_valid, wb_data_out[31:0], in_ready, stall_cycles, wb_reg_out, seq[i]);
            end
        end
        drive(1'b0, 2'b00, 32'h0);
        step();
        checks++;
        if (out_valid !== 1'b0 || wb_reg_out !== 2'b00) begin
            failures++;
            $display("FAIL stream_drain: valid=%b we=%b want 0/00", out_valid, wb_reg_out);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'hAAAA_0001);
        step();
        checks++;
        if (out_valid !== 1'b1 || wb_data_out[31:0] !== 32'hAAAA_0001 || in_ready !== 1'b1
            || stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL bp_pushA: valid=%b data=%h rdy=%b stall=%0d want 1/aaaa0001/1/0",
                     out_valid, wb_data_out[31:0], in_ready, stall_cycles);
        end
        drive(1'b1, 2'b01, 32'hBBBB_0002);
        step();
        checks++;
        if (in_ready !== 1'b0 || stall_cycles !== 16'd1 || wb_data_out[31:0] !== 32'hAAAA_0001) begin
            failures++;
            $display("FAIL bp_full: rdy=%b stall=%0d data=%h want 0/1/aaaa0001",
                     in_ready, stall_cycles, wb_data_out[31:0]);
        end
        drive(1'b1, 2'b01, 32'hCCCC_0003);
        for (int i = 2; i <= 3; i++) begin
            step();
            checks++;
            if (in_ready !== 1'b0 || stall_cycles !== SW'(i) || wb_data_out[31:0] !== 32'hAAAA_0001) begin
                failures++;
                $display("FAIL bp_hold_%0d: rdy=%b stall=%0d data=%h want 0/%0d/aaaa0001",
                         i, in_ready, stall_cycles, wb_data_out[31:0], i);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || wb_data_out[31:0] !== 32'hBBBB_0002 || in_ready !== 1'b1
            || stall_cycles !== 16'd3) begin
            failures++;
            $display("FAIL bp_popA: valid=%b data=%h rdy=%b stall=%0d want 1/bbbb0002/1/3",
                     out_valid, wb_data_out[31:0], in_ready, stall_cycles);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || wb_data_out[31:0] !== 32'hCCCC_0003) begin
            failures++;
            $display("FAIL bp_popB: valid=%b data=%h want 1/cccc0003", out_valid, wb_data_out[31:0]);
        end
        drive(1'b0, 2'b00, 32'h0);
        step();
        checks++;
        if (out_valid !== 1'b0 || stall_cycles !== 16'd3) begin
            failures++;
            $display("FAIL bp_popC: valid=%b stall=%0d want 0/3", out_valid, stall_cycles);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 32'hD0D0_0004);
        step();
        drive(1'b1, 2'b11, 32'hE0E0_0005);
        step();
        checks++;
        if (in_ready !== 1'b0 || stall_cycles !== 16'd4) begin
            failures++;
            $display("FAIL flush_setup: rdy=%b stall=%0d want 0/4", in_ready, stall_cycles);
        end
        // Flush while FULL with a new bundle presented and WB ready.
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 2'b11, 32'hF0F0_0006);
        step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || wb_reg_out !== 2'b00 || in_ready !== 1'b1
            || wb_data_out !== 64'd0 || stall_cycles !== 16'd4) begin
            failures++;
            $display("FAIL flush_state: valid=%b we=%b rdy=%b data=%h stall=%0d want 0/00/1/0/4",
                     out_valid, wb_reg_out, in_ready, wb_data_out, stall_cycles);
        end
        drive(1'b0, 2'b00, 32'h0);
        step(); step();
        checks++;
        if (out_valid !== 1'b0 || wb_data_out[31:0] === 32'hF0F0_0006) begin
            failures++;
            $display("FAIL flush_discard: valid=%b data=%h want 0/not f0f00006",
                     out_valid, wb_data_out[31:0]);
        end
        drive(1'b1, 2'b01, 32'h6060_0007);
        step();
        checks++;
        if (out_valid !== 1'b1 || wb_data_out[31:0] !== 32'h6060_0007) begin
            failures++;
            $display("FAIL flush_resume: valid=%b data=%h want 1/60600007", out_valid, wb_data_out[31:0]);
        end
        drive(1'b0, 2'b00, 32'h0);
        step();
    endtask

    task automatic test_lanes();
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        wb_reg_in  = 2'b10;
        wb_data_in = {32'hCAFE_F00D, 32'hDEAD_BEEF};
        vaddr_in   = {5'd21, 5'd7};
        paddr_in   = {6'd37, 6'd12};
        ali_in     = {3'd5, 3'd3};
        step();
        checks++;
        if (wb_reg_out !== 2'b10 || paddr_out[11:6] !== 6'd37 || ali_out[5:3] !== 3'd5) begin
            failures++;
            $display("FAIL lane1: we=%b paddr1=%0d ali1=%0d want 10/37/5",
                     wb_reg_out, paddr_out[11:6], ali_out[5:3]);
        end
        checks++;
        if (wb_data_out !== 64'hCAFE_F00D_DEAD_BEEF || vaddr_out !== {5'd21, 5'd7}
            || paddr_out[5:0] !== 6'd12 || ali_out[2:0] !== 3'd3) begin
            failures++;
            $display("FAIL lane0: data=%h vaddr=%h paddr0=%0d ali0=%0d want cafef00ddeadbeef/2a7/12/3",
                     wb_data_out, vaddr_out, paddr_out[5:0], ali_out[2:0]);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || wb_reg_out !== 2'b00 || paddr_out[11:6] !== 6'd37) begin
            failures++;
            $display("FAIL lane_gate: valid=%b we=%b paddr1=%0d want 0/00/37",
                     out_valid, wb_reg_out, paddr_out[11:6]);
        end
    endtask

    task automatic test_reset_midway();
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 32'h1234_5678);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 2'b00, 32'h0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cycles !== 16'd0
            || wb_data_out !== 64'd0 || wb_reg_out !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid: valid=%b rdy=%b stall=%0d data=%h we=%b want 0/1/0/0/00",
                     out_valid, in_ready, stall_cycles, wb_data_out, wb_reg_out);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_drop: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        s_rst = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b0;
        step();
        s_rst = 1'b0;
        s_in_valid = 1'b1;
        step();
        s_in_valid = 1'b0;
        checks++;
        if (s_out_valid !== 1'b1 || s_stall !== 4'd0 || s_data_out !== 32'h0000_00A5) begin
            failures++;
            $display("FAIL sat_load: valid=%b stall=%0d data=%h want 1/0/a5", s_out_valid, s_stall, s_data_out);
        end
        for (int i = 0; i < 14; i++) step();
        checks++;
        if (s_stall !== 4'd14) begin
            failures++;
            $display("FAIL sat_14: stall=%0d want 14", s_stall);
        end
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (s_stall !== 4'd15 || s_out_valid !== 1'b1 || s_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL sat_15: stall=%0d valid=%b rdy=%b want 15/1/1", s_stall, s_out_valid, s_in_ready);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        s_rst = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_lanes();
        test_reset_midway();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_mem2wb_skid.md
Name: pipeline_mem2wb_skid

Overview:
Parametrised successor to the single-lane MEM-to-WB pipeline register. It carries LANES independent writeback lanes with a valid/ready handshake in place of a global stall. A 2-entry skid buffer holds data, so in_ready is a registered signal and MEM never sees a combinational path from WB back-pressure. It sits between the memory stage and the writeback/commit logic (register file and active list).

Parameters:
LANES, 2, number of parallel writeback lanes (>=1)
DATA_WIDTH, 32, writeback data width per lane
VREG_WIDTH, 5, architectural (virtual) register address width
PREG_WIDTH, 6, physical register address width
FREE_LIST_WIDTH, 3, active-list index width
STALL_CNT_WIDTH, 16, back-pressure cycle counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  squash all held and incoming entries
in_valid  in  1  MEM presents a bundle
in_ready  out  1  block accepts a bundle (registered)
wb_reg_in  in  LANES  per-lane write enable
wb_data_in  in  LANES*DATA_WIDTH  per-lane data; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
virtual_write_addr_in  in  LANES*VREG_WIDTH  per-lane architectural destination
physical_write_addr_in  in  LANES*PREG_WIDTH  per-lane physical destination
active_list_index_in  in  LANES*FREE_LIST_WIDTH  per-lane active-list index
out_valid  out  1  bundle available to WB
out_ready  in  1  WB consumes the bundle
wb_reg_out  out  LANES  per-lane write enable, forced to 0 when out_valid=0
wb_data_out, virtual_write_addr_out, physical_write_addr_out, active_list_index_out  out  same widths as the inputs  per-lane payload
stall_cycles  out  STALL_CNT_WIDTH  saturating count of cycles with out_valid & !out_ready

Behaviour:
- Storage: main register M (drives the outputs) and skid register S. Each holds the full LANES-wide payload plus a valid bit.
- Handshakes: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Output and ready definitions: out_valid = M.valid; in_ready = !S.valid.
- States: EMPTY (M,S invalid), ONE (M valid), FULL (M,S valid).
- EMPTY: acc -> M<=in, go to ONE.
- ONE: acc & pop -> M<=in, stay in ONE. acc & !pop -> S<=in, go to FULL. !acc & pop -> go to EMPTY. Otherwise hold.
- FULL: in_ready=0, so no accept. pop -> M<=S, S invalid, go to ONE. Otherwise hold.
- Ordering: strict FIFO; no bundle is lost or duplicated.
- Latency: in to out is 1 cycle when EMPTY, or when ONE and popping.
- Flush: takes priority over every transition. Next cycle is EMPTY, both payloads are zeroed, and any bundle accepted in the flush cycle is discarded. in_ready is 1 the cycle after a flush.
- Reset (rst=1 at clk edge):
  - Returns to EMPTY and zeroes all payload.
  - out_valid=0, in_ready=1, wb_reg_out=0, all payload outputs 0, stall_cycles=0.
  - Reset mid-transfer discards both entries.
- Output gating: wb_reg_out[i] = M.wb_reg[i] & out_valid. Other payload outputs show M contents even when invalid; consumers must gate them with wb_reg_out.
- stall_cycles:
  - Increments when out_valid & !out_ready.
  - Saturates at all-ones.
  - Cleared only by rst; flush does not clear it.
- Lanes are stored and moved together; no per-lane handshaking.
- Parameter widths are exact; no truncation or extension of the packed buses.

Test Plan:
- Reset then idle (rst=1 for 2 cycles, then 0): out_valid=0, in_ready=1, wb_reg_out=2'b00, stall_cycles=0.
- Streaming: out_ready=1, in_valid=1 with wb_data_in lane0 = 0x11111111, 0x22222222, 0x33333333 on consecutive cycles. wb_data_out lane0 shows the same sequence one cycle later, in_ready stays 1, stall_cycles stays 0.
- Back-pressure: out_ready=0, push A then B. After B, in_ready=0, C is held by MEM, and stall_cycles counts 1,2,3. Raise out_ready: outputs are A, then B, then C, and in_ready returns to 1 one cycle after the pop of A.
- Flush while FULL and in_valid=1: next cycle out_valid=0, wb_reg_out=0, in_ready=1. The bundle presented in the flush cycle never appears; stall_cycles is unchanged.
- Saturation: STALL_CNT_WIDTH=4, out_ready=0 for 20 cycles with one entry held. stall_cycles stops at 15.
- Lane independence: LANES=2, wb_reg_in=2'b10, lane1 physical_write_addr_in=6'd37, active_list_index_in lane1=3'd5. Output shows wb_reg_out=2'b10, lane1 physical_write_addr_out=37 and active_list_index_out=5; lane0 payload passes through unchanged.
